// File: rtl/branch_pkg.sv
// Shared encodings for the branch resolution block.
// Holds the req_kind encodings, the branch func3 condition codes and the FSM state constants.
// Imported by branch_ctrl and br_cond.
package branch_pkg;

    // Instruction kind presented by decode
    typedef logic [1:0] kind_t;
    localparam kind_t KIND_BRANCH = 2'b00;
    localparam kind_t KIND_JAL    = 2'b01;
    localparam kind_t KIND_JALR   = 2'b10;
    localparam kind_t KIND_RSVD   = 2'b11;

    // Branch condition codes (func3). 010 and 011 are unused encodings.
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Controller FSM states
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EVAL = 2'd1;
    localparam state_t ST_RESP = 2'd2;

endpackage

// File: rtl/br_cond.sv
// Branch condition test: pass=1 when data1 <op> data2 holds for the given func3.
// Latency: purely combinational. Backpressure: none.
// Ports: data1/data2 operands, func3 condition code, pass result (0 for unused codes).
module br_cond
    import branch_pkg::*;
(
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    input  logic [2:0]  func3,
    output logic        pass
);

    always_comb begin
        pass = 1'b0;
        case (func3)
            F3_BEQ:  pass = (data1 == data2);
            F3_BNE:  pass = (data1 != data2);
            F3_BLT:  pass = ($signed(data1) <  $signed(data2));
            F3_BGE:  pass = ($signed(data1) >= $signed(data2));
            F3_BLTU: pass = (data1 <  data2);
            F3_BGEU: pass = (data1 >= data2);
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_ctrl.sv
// Branch/jump resolution: accepts one decoded control-flow op, resolves redirect/target/link, counts branches.
// Latency: request accepted in cycle N produces rsp_valid in cycle N+2.
// Backpressure: response held stable until rsp_ready; req_ready low from accept until the cycle after the handshake.
// Ports: req_* request from decode, rsp_* response to fetch, flush strobe, cnt_* branch statistics.
module branch_ctrl
    import branch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_pc,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic [31:0] req_imm,
    input  logic [2:0]  req_func3,
    input  logic [1:0]  req_kind,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_redirect,
    output logic [31:0] rsp_target,
    output logic [31:0] rsp_link,
    output logic        rsp_illegal,
    output logic        flush,
    input  logic        cnt_clr,
    output logic [31:0] cnt_total,
    output logic [31:0] cnt_taken
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, rs1_q, rs2_q, imm_q;
    logic [2:0]  func3_q;
    kind_t       kind_q;
    logic        redirect_q, illegal_q;
    logic [31:0] target_q, link_q;
    logic [31:0] cnt_total_q, cnt_taken_q;
    logic [31:0] cnt_total_d, cnt_taken_d;

    logic        accept, rsp_hs, cond_pass;
    logic        is_branch, bad_enc, take, misalign;
    logic [31:0] tgt_sum, eval_target;
    logic        count_ok;

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign accept    = req_valid && req_ready;
    assign rsp_hs    = rsp_valid && rsp_ready;

    br_cond u_br_cond (
        .data1 (rs1_q),
        .data2 (rs2_q),
        .func3 (func3_q),
        .pass  (cond_pass)
    );

    // Evaluation works only from the captured copies so decode may change req_* freely after accept
    assign is_branch   = (kind_q == KIND_BRANCH);
    assign bad_enc     = (kind_q == KIND_RSVD) || (is_branch && (func3_q[2:1] == 2'b01));
    assign tgt_sum     = ((kind_q == KIND_JALR) ? rs1_q : pc_q) + imm_q;
    assign eval_target = (kind_q == KIND_JALR) ? {tgt_sum[31:1], 1'b0} : tgt_sum;
    assign take        = (kind_q == KIND_JAL) || (kind_q == KIND_JALR) ||
                         (is_branch && cond_pass && !bad_enc);
    // A taken op landing on a half-word boundary cannot be fetched: report it instead of redirecting
    assign misalign    = take && eval_target[1];

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_EVAL;
            ST_EVAL: state_d = ST_RESP;
            ST_RESP: if (rsp_hs) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
            func3_q <= '0;
            kind_q  <= KIND_BRANCH;
        end else begin
            state_q <= state_d;
            if (accept) begin
                pc_q    <= req_pc;
                rs1_q   <= req_rs1;
                rs2_q   <= req_rs2;
                imm_q   <= req_imm;
                func3_q <= req_func3;
                kind_q  <= req_kind;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_q <= 1'b0;
            illegal_q  <= 1'b0;
            target_q   <= '0;
            link_q     <= '0;
        end else if (state_q == ST_EVAL) begin
            redirect_q <= take && !misalign;
            illegal_q  <= bad_enc || misalign;
            target_q   <= eval_target;
            link_q     <= pc_q + 32'd4;
        end
    end

    // Only well-formed conditional branches are counted, at the moment fetch takes the response
    assign count_ok    = rsp_hs && is_branch && !illegal_q;
    assign cnt_total_d = cnt_clr ? '0 : cnt_total_q + {31'b0, count_ok};
    assign cnt_taken_d = cnt_clr ? '0 : cnt_taken_q + {31'b0, count_ok && redirect_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_total_q <= '0;
            cnt_taken_q <= '0;
        end else begin
            cnt_total_q <= cnt_total_d;
            cnt_taken_q <= cnt_taken_d;
        end
    end

    assign rsp_redirect = redirect_q;
    assign rsp_illegal  = illegal_q;
    assign rsp_target   = target_q;
    assign rsp_link     = link_q;
    assign flush        = rsp_hs && redirect_q;
    assign cnt_total    = cnt_total_q;
    assign cnt_taken    = cnt_taken_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: table of ops with expected responses fed through a scoreboard queue,
// plus sequences for backpressure, counter wrap/clear and reset during a pending response.
module tb_branch_ctrl;
    import branch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [31:0] req_pc, req_rs1, req_rs2, req_imm;
    logic [2:0]  req_func3;
    logic [1:0]  req_kind;
    logic        rsp_valid, rsp_ready, rsp_redirect, rsp_illegal, flush, cnt_clr;
    logic [31:0] rsp_target, rsp_link, cnt_total, cnt_taken;

    always #5 clk = ~clk;

    branch_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_pc(req_pc), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
        .req_func3(req_func3), .req_kind(req_kind),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_redirect(rsp_redirect), .rsp_target(rsp_target), .rsp_link(rsp_link),
        .rsp_illegal(rsp_illegal), .flush(flush),
        .cnt_clr(cnt_clr), .cnt_total(cnt_total), .cnt_taken(cnt_taken)
    );

    typedef struct {
        logic [1:0]  kind;
        logic [2:0]  f3;
        logic [31:0] pc, rs1, rs2, imm;
        logic        redir;
        logic [31:0] tgt, link;
        logic        ill;
    } vec_t;

    vec_t        tbl[13];
    vec_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_total = '0;
    logic [31:0] exp_taken = '0;

    function automatic vec_t mk(logic [1:0] k, logic [2:0] f, logic [31:0] pc, logic [31:0] a,
                                logic [31:0] b, logic [31:0] imm, logic r, logic [31:0] t,
                                logic [31:0] l, logic il);
        vec_t v;
        v.kind = k; v.f3 = f; v.pc = pc; v.rs1 = a; v.rs2 = b; v.imm = imm;
        v.redir = r; v.tgt = t; v.link = l; v.ill = il;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_rsp(input string tag, input vec_t e);
        chk({tag, " redirect"}, {31'b0, rsp_redirect}, {31'b0, e.redir});
        chk({tag, " target"},   rsp_target, e.tgt);
        chk({tag, " link"},     rsp_link, e.link);
        chk({tag, " illegal"},  {31'b0, rsp_illegal}, {31'b0, e.ill});
    endtask

    // Present one request in the next cycle; it must be accepted there
    task automatic issue(input vec_t v);
        @(negedge clk);
        req_valid = 1'b1;
        req_pc = v.pc; req_rs1 = v.rs1; req_rs2 = v.rs2; req_imm = v.imm;
        req_func3 = v.f3; req_kind = v.kind;
        chk("accept req_ready", {31'b0, req_ready}, 32'd1);
        sb.push_back(v);
        @(negedge clk);
        req_valid = 1'b0;
        // Scramble the request bus: the DUT must be working from its captured copy
        req_pc = $urandom; req_rs1 = $urandom; req_rs2 = $urandom; req_imm = $urandom;
        req_func3 = 3'($urandom); req_kind = 2'($urandom);
        chk("eval rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("eval req_ready", {31'b0, req_ready}, 32'd0);
    endtask

    // Wait for the response, compare against the scoreboard, stall, then hand it off
    task automatic collect(input int stall, input logic clr_on_hs);
        int   n = 0;
        vec_t e;
        @(negedge clk);
        while (!rsp_valid && n < 10) begin
            n++;
            @(negedge clk);
        end
        chk("rsp latency extra cycles", n, 0);
        chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: got empty queue expected one entry");
            return;
        end
        e = sb.pop_front();
        chk_rsp("rsp", e);
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            chk_rsp("stall", e);
            chk("stall rsp_valid", {31'b0, rsp_valid}, 32'd1);
            chk("stall req_ready", {31'b0, req_ready}, 32'd0);
            chk("stall flush", {31'b0, flush}, 32'd0);
        end
        rsp_ready = 1'b1;
        cnt_clr   = clr_on_hs;
        #1;
        chk("flush on handshake", {31'b0, flush}, {31'b0, e.redir});
        @(posedge clk);
        if (clr_on_hs) begin
            exp_total = '0;
            exp_taken = '0;
        end else if (e.kind == KIND_BRANCH && !e.ill) begin
            exp_total = exp_total + 32'd1;
            if (e.redir) exp_taken = exp_taken + 32'd1;
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        cnt_clr   = 1'b0;
        chk("post rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("post req_ready", {31'b0, req_ready}, 32'd1);
        chk("post flush", {31'b0, flush}, 32'd0);
        chk("cnt_total", cnt_total, exp_total);
        chk("cnt_taken", cnt_taken, exp_taken);
    endtask

    task automatic clear_counters();
        @(negedge clk);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        exp_total = '0;
        exp_taken = '0;
        chk("clr cnt_total", cnt_total, 32'd0);
        chk("clr cnt_taken", cnt_taken, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vb;
        //           kind         f3       pc            rs1           rs2           imm        redir tgt          link         ill
        tbl[0]  = mk(KIND_BRANCH, F3_BEQ,  32'h80000000, 32'd5,        32'd5,        32'h10,       1, 32'h80000010, 32'h80000004, 0);
        tbl[1]  = mk(KIND_BRANCH, F3_BLT,  32'h00001000, 32'hFFFFFFFF, 32'd1,        32'h20,       1, 32'h00001020, 32'h00001004, 0);
        tbl[2]  = mk(KIND_BRANCH, F3_BLTU, 32'h00001000, 32'hFFFFFFFF, 32'd1,        32'h20,       0, 32'h00001020, 32'h00001004, 0);
        tbl[3]  = mk(KIND_JALR,   3'b000,  32'h00002000, 32'h80000003, 32'd0,        32'h0,        0, 32'h80000002, 32'h00002004, 1);
        tbl[4]  = mk(KIND_BRANCH, F3_BNE,  32'h00000100, 32'd3,        32'd3,        32'hFFFFFFF8, 0, 32'h000000F8, 32'h00000104, 0);
        tbl[5]  = mk(KIND_BRANCH, F3_BGE,  32'h00000400, 32'hFFFFFFFB, 32'hFFFFFFFB, 32'hFFFFFFF0, 1, 32'h000003F0, 32'h00000404, 0);
        tbl[6]  = mk(KIND_BRANCH, F3_BGEU, 32'h00000000, 32'd1,        32'hFFFFFFFF, 32'h4,        0, 32'h00000004, 32'h00000004, 0);
        tbl[7]  = mk(KIND_BRANCH, 3'b010,  32'h00000500, 32'd7,        32'd7,        32'h8,        0, 32'h00000508, 32'h00000504, 1);
        tbl[8]  = mk(KIND_RSVD,   3'b000,  32'h00000600, 32'd0,        32'd0,        32'h8,        0, 32'h00000608, 32'h00000604, 1);
        tbl[9]  = mk(KIND_JAL,    3'b000,  32'hFFFFFFFC, 32'd0,        32'd0,        32'h8,        1, 32'h00000004, 32'h00000000, 0);
        tbl[10] = mk(KIND_BRANCH, F3_BEQ,  32'h00000000, 32'd9,        32'd9,        32'h6,        0, 32'h00000006, 32'h00000004, 1);
        tbl[11] = mk(KIND_JALR,   3'b000,  32'h00003000, 32'h00001001, 32'd0,        32'h4,        1, 32'h00001004, 32'h00003004, 0);
        tbl[12] = mk(KIND_BRANCH, F3_BLT,  32'h00000000, 32'd1,        32'hFFFFFFFF, 32'h8,        0, 32'h00000008, 32'h00000004, 0);

        rst_n = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; cnt_clr = 1'b0;
        req_pc = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0; req_func3 = '0; req_kind = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset redirect", {31'b0, rsp_redirect}, 32'd0);
        chk("reset illegal", {31'b0, rsp_illegal}, 32'd0);
        chk("reset flush", {31'b0, flush}, 32'd0);
        chk("reset target", rsp_target, 32'd0);
        chk("reset link", rsp_link, 32'd0);
        chk("reset cnt_total", cnt_total, 32'd0);
        chk("reset cnt_taken", cnt_taken, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("reset req_ready", {31'b0, req_ready}, 32'd1);

        // Table sweep
        for (int i = 0; i < 13; i++) begin
            if (i == 1) clear_counters();
            issue(tbl[i]);
            collect(0, 1'b0);
            if (i == 0) chk("beq cnt_taken", cnt_taken, 32'd1);
            if (i == 2) begin
                chk("blt/bltu cnt_total", cnt_total, 32'd2);
                chk("blt/bltu cnt_taken", cnt_taken, 32'd1);
            end
        end

        // Backpressure: second request held on the bus during EVAL/RESP is taken only after the handshake
        issue(tbl[5]);
        vb = tbl[1];
        req_valid = 1'b1;
        req_pc = vb.pc; req_rs1 = vb.rs1; req_rs2 = vb.rs2; req_imm = vb.imm;
        req_func3 = vb.f3; req_kind = vb.kind;
        collect(5, 1'b0);
        sb.push_back(vb);
        @(negedge clk);
        req_valid = 1'b0;
        chk("bp second accepted", {31'b0, req_ready}, 32'd0);
        chk("bp second rsp_valid", {31'b0, rsp_valid}, 32'd0);
        collect(0, 1'b0);

        // Counter wrap from all-ones
        @(negedge clk);
        force dut.cnt_total_d = 32'hFFFFFFFF;
        force dut.cnt_taken_d = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        release dut.cnt_total_d;
        release dut.cnt_taken_d;
        exp_total = 32'hFFFFFFFF;
        exp_taken = 32'hFFFFFFFF;
        chk("preset cnt_total", cnt_total, 32'hFFFFFFFF);
        issue(tbl[0]);
        collect(0, 1'b0);
        chk("wrap cnt_total", cnt_total, 32'd0);
        chk("wrap cnt_taken", cnt_taken, 32'd0);

        // Clear coincident with an increment
        issue(tbl[0]);
        collect(0, 1'b0);
        issue(tbl[1]);
        collect(0, 1'b1);
        chk("clr-win cnt_total", cnt_total, 32'd0);
        chk("clr-win cnt_taken", cnt_taken, 32'd0);

        // Reset while a response is pending
        issue(tbl[0]);
        collect(0, 1'b0);
        issue(tbl[0]);
        @(negedge clk);
        chk("pre-reset rsp_valid", {31'b0, rsp_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid-reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
        rsp_ready = 1'b1;
        #1;
        chk("mid-reset flush", {31'b0, flush}, 32'd0);
        chk("mid-reset cnt_total", cnt_total, 32'd0);
        chk("mid-reset cnt_taken", cnt_taken, 32'd0);
        chk("mid-reset target", rsp_target, 32'd0);
        sb.delete();
        exp_total = '0;
        exp_taken = '0;
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b0;
        issue(tbl[1]);
        collect(0, 1'b0);
        chk("post-reset cnt_taken", cnt_taken, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state on rising edge.
REQ-002 SHALL have port: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have ports: req_valid in 1 and req_ready out 1, the request handshake from decode.
REQ-004 SHALL have ports: req_pc, req_rs1, req_rs2, req_imm  in  32 each  instruction PC, source operands, sign-extended immediate.
REQ-005 SHALL have ports: req_func3  in  3  branch condition; req_kind  in  2  00 BRANCH, 01 JAL, 10 JALR, 11 reserved.
REQ-006 SHALL have ports: rsp_valid out 1 and rsp_ready in 1, the response handshake to the PC/fetch stage.
REQ-007 SHALL have ports: rsp_redirect out 1 (take target); rsp_target out 32; rsp_link out 32 (pc+4); rsp_illegal out 1.
REQ-008 SHALL have port: flush  out  1  pipeline flush strobe.
REQ-009 SHALL have ports: cnt_clr in 1; cnt_total out 32 (resolved branches); cnt_taken out 32 (taken branches).

Function
REQ-010 SHALL implement FSM IDLE -> EVAL -> RESP -> IDLE; req_ready=1 only in IDLE; rsp_valid=1 only in RESP.
REQ-011 SHALL capture all req_* fields into registers when req_valid&&req_ready, then enter EVAL.
REQ-012 SHALL in EVAL evaluate condition and target from captured registers only, register all rsp_* fields, and enter RESP; latency: accept at cycle N gives rsp_valid at N+2.
REQ-013 SHALL hold every rsp_* output stable in RESP until rsp_valid&&rsp_ready, then return to IDLE; no new request is accepted in that same cycle.
REQ-014 SHALL evaluate BRANCH conditions as: 000 rs1==rs2, 001 rs1!=rs2, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned geu.
REQ-015 SHALL treat BRANCH with func3 010 or 011, and any req_kind 11, as illegal: rsp_illegal=1, rsp_redirect=0.
REQ-016 SHALL compute target modulo 2^32: BRANCH/JAL pc+imm; JALR (rs1+imm) with bit0 cleared; rsp_link=pc+4 wrapping, for all kinds.
REQ-017 SHALL assert redirect for JAL, JALR, and BRANCH with true condition; if target[1]=1 on such a redirect, SHALL set rsp_illegal=1 and rsp_redirect=0.
REQ-018 SHALL drive flush = rsp_valid && rsp_ready && rsp_redirect combinationally, one cycle per accepted redirect.
REQ-019 SHALL increment cnt_total on each accepted response of kind BRANCH with rsp_illegal=0, and cnt_taken when that response also has rsp_redirect=1.
REQ-020 SHALL wrap both counters from 0xFFFFFFFF to 0.
REQ-021 SHALL make cnt_clr synchronous, with cnt_clr winning over a same-cycle increment.
REQ-022 SHALL ignore req_* while not in IDLE and ignore rsp_ready outside RESP.

Reset
REQ-023 SHALL on rst_n=0 immediately force: state IDLE; rsp_valid, rsp_redirect, rsp_illegal, flush = 0; rsp_target, rsp_link, cnt_total, cnt_taken = 0; req_ready=1 once rst_n deasserts.
REQ-024 SHALL on reset during EVAL or RESP discard the pending request with no response, flush or count.

Structure
REQ-025 SHALL place req_kind encodings, func3 condition encodings and the FSM state enum in shared package branch_pkg.
REQ-026 SHALL isolate the condition test in one combinational sub-module br_cond (inputs data1, data2, func3; output pass), instantiated once.

Verification
REQ-027 SHALL verify BEQ: pc=0x80000000, rs1=rs2=5, imm=0x10 -> rsp_valid two cycles after accept, redirect=1, target=0x80000010, link=0x80000004, flush on accept, cnt_taken=1.
REQ-028 SHALL verify BLT vs BLTU: rs1=0xFFFFFFFF, rs2=1 -> func3 100 taken, func3 110 not taken, cnt_total=2, cnt_taken=1.
REQ-029 SHALL verify JALR: rs1=0x80000003, imm=0 -> target=0x80000002, rsp_illegal=1, redirect=0, no flush, counters unchanged.
REQ-030 SHALL verify backpressure: rsp_ready held 0 for 5 cycles in RESP -> outputs stable, req_ready=0, second request accepted only in the cycle after handshake.
REQ-031 SHALL verify wrap and clear: pc=0xFFFFFFFC JAL imm=8 -> target=0x00000004, link=0; counters preset to 0xFFFFFFFF by stimulus wrap to 0; cnt_clr coincident with an increment yields 0.
REQ-032 SHALL verify reset mid-RESP: rst_n low while rsp_valid=1 -> rsp_valid=0 asynchronously, no flush, counters 0, next request processed normally.
